matriz_varredura: RTL and testbench

- Row-scan driver for the 5-column x 7-row LED matrix; it consumes the frame pattern ROMs (quadro_N).
- Generates the 3-bit row index (contador) that addresses the ROMs and latches the returned 5-bit column pattern.
- Drives one active-low row line at a time, with an inter-row blanking gap to suppress ghosting.
- Selects which frame is shown; frame changes only at a frame boundary.

---
 rtl/matriz_pkg.sv | 15 +
 rtl/matriz_varredura_decod_linha.sv | 19 +
 rtl/matriz_varredura.sv | 124 ++++++++++++
 tb/tb_matriz_varredura.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/matriz_pkg.sv
// Shared definitions for the LED matrix display blocks: scan FSM states,
// the all-rows-off pattern and the default matrix geometry.
package matriz_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    APAGA  = 2'd1,
    MOSTRA = 2'd2
  } estado_t;

  localparam logic [6:0] LINHAS_OFF   = 7'h7F;
  localparam int         NUM_ROWS_DEF = 7;
  localparam int         COL_W        = 5;

endpackage

// File: rtl/matriz_varredura_decod_linha.sv
// 3-to-7 active-low one-hot row decoder. Disabled or out-of-range index
// (7) leaves every row off.
module decod_linha
  import matriz_pkg::*;
(
  input  logic       en,
  input  logic [2:0] idx,
  output logic [6:0] linhas
);

  // NOTE: default first so every path assigns linhas -- no latch inferred.
  always_comb begin
    linhas = LINHAS_OFF;
    for (int i = 0; i < 7; i++) begin
      if (en && idx == 3'(i)) linhas[i] = 1'b0;
    end
  end

endmodule

// File: rtl/matriz_varredura.sv
// Row-scan driver for the 5x7 LED matrix: blank gap, then show each row.
// Optional brightness control with `define MATRIZ_VARREDURA_BRILHO_EN.
module matriz_varredura
  import matriz_pkg::*;
#(
  parameter int PRESCALE     = 4,
  parameter int BLANK_CYCLES = 2,
  parameter int NUM_ROWS     = NUM_ROWS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             habilita,
  input  logic [2:0]       quadro_sel,
  input  logic [COL_W-1:0] colunas_in,
`ifdef MATRIZ_VARREDURA_BRILHO_EN
  input  logic [2:0]       brilho,
`endif
  output logic [2:0]       contador,
  output logic [2:0]       quadro_atual,
  output logic [6:0]       linhas,
  output logic [COL_W-1:0] colunas,
  output logic             fim_quadro
);

  localparam int TMAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] SHOW_LAST  = TW'(PRESCALE - 1);
  localparam logic [2:0]    LAST_ROW   = 3'(NUM_ROWS - 1);

  estado_t       estado;
  logic [TW-1:0] timer;
  logic [6:0]    linha_dec;

  decod_linha u_decod_linha (
    .en    (habilita),
    .idx   (contador),
    .linhas(linha_dec)
  );

`ifdef MATRIZ_VARREDURA_BRILHO_EN
  logic [2:0] brilho_lat;
  logic       apaga_cedo;

  // Row goes dark once the next show cycle reaches the duty limit.
  always_comb begin
    apaga_cedo = (int'(timer) + 1) >= (int'(brilho_lat) + 1) * (PRESCALE / 8);
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado       <= OCIOSO;
      timer        <= '0;
      contador     <= '0;
      quadro_atual <= '0;
      linhas       <= LINHAS_OFF;
      colunas      <= '0;
      fim_quadro   <= 1'b0;
`ifdef MATRIZ_VARREDURA_BRILHO_EN
      brilho_lat   <= '0;
`endif
    end else begin
      fim_quadro <= 1'b0;
      if (!habilita) begin
        estado   <= OCIOSO;
        timer    <= '0;
        contador <= '0;
        linhas   <= LINHAS_OFF;
        colunas  <= '0;
      end else begin
        case (estado)
          OCIOSO: begin
            estado       <= APAGA;
            timer        <= '0;
            contador     <= '0;
            quadro_atual <= quadro_sel;
          end
          APAGA: begin
            if (timer == BLANK_LAST) begin
              estado  <= MOSTRA;
              timer   <= '0;
              colunas <= colunas_in;
              linhas  <= linha_dec;
`ifdef MATRIZ_VARREDURA_BRILHO_EN
              brilho_lat <= brilho;
`endif
            end else begin
              timer <= timer + 1'b1;
            end
          end
          MOSTRA: begin
            if (timer == SHOW_LAST) begin
              estado  <= APAGA;
              timer   <= '0;
              linhas  <= LINHAS_OFF;
              colunas <= '0;
              if (contador == LAST_ROW) begin
                contador     <= '0;
                fim_quadro   <= 1'b1;
                quadro_atual <= quadro_sel;
              end else begin
                contador <= contador + 3'd1;
              end
            end else begin
              timer <= timer + 1'b1;
`ifdef MATRIZ_VARREDURA_BRILHO_EN
              if (apaga_cedo) begin
                linhas  <= LINHAS_OFF;
                colunas <= '0;
              end
`endif
            end
          end
          default: estado <= OCIOSO;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matriz_varredura.sv
// Self-checking bench for matriz_varredura: directed phases plus random
// enable/frame/brightness stimulus checked against a position-based model.
module tb_matriz_varredura;

`ifdef MATRIZ_VARREDURA_BRILHO_EN
  localparam int PRESCALE = 8;
`else
  localparam int PRESCALE = 4;
`endif
  localparam int BLANK = 2;
  localparam int NR    = 7;
  localparam int RP    = BLANK + PRESCALE;
  localparam int FP    = NR * RP;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       habilita = 1'b0;
  logic [2:0] quadro_sel = 3'd0;
  logic [4:0] colunas_in;
  logic [2:0] contador;
  logic [2:0] quadro_atual;
  logic [6:0] linhas;
  logic [4:0] colunas;
  logic       fim_quadro;
`ifdef MATRIZ_VARREDURA_BRILHO_EN
  logic [2:0] brilho = 3'd7;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  matriz_varredura #(
    .PRESCALE    (PRESCALE),
    .BLANK_CYCLES(BLANK),
    .NUM_ROWS    (NR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .habilita    (habilita),
    .quadro_sel  (quadro_sel),
    .colunas_in  (colunas_in),
`ifdef MATRIZ_VARREDURA_BRILHO_EN
    .brilho      (brilho),
`endif
    .contador    (contador),
    .quadro_atual(quadro_atual),
    .linhas      (linhas),
    .colunas     (colunas),
    .fim_quadro  (fim_quadro)
  );

  always #5 clk = ~clk;

  // Frame ROM model: frame 0 gives {row,2'b01}; other frames xor in the frame number.
  function automatic logic [4:0] rom(input logic [2:0] row, input logic [2:0] frame);
    return {row, 2'b01} ^ {frame, 2'b00};
  endfunction

  assign colunas_in = rom(contador, quadro_atual);

  // Model: scanning flag, cycles elapsed since the scan started, shown frame.
  bit         en_m    = 1'b0;
  int         p       = 0;
  logic [2:0] frame_m = 3'd0;
  logic [2:0] bri_row = 3'd7;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    en_m    = 1'b0;
    p       = 0;
    frame_m = 3'd0;
  endtask

  task automatic model_edge();
    if (!habilita) begin
      en_m = 1'b0;
      p    = 0;
    end else if (!en_m) begin
      en_m    = 1'b1;
      p       = 0;
      frame_m = quadro_sel;
    end else begin
      p++;
      if (p % FP == 0) frame_m = quadro_sel;
`ifdef MATRIZ_VARREDURA_BRILHO_EN
      if (p % RP == BLANK) bri_row = brilho;
`endif
    end
  endtask

  task automatic compare();
    logic [6:0] el;
    logic [4:0] ec;
    logic [2:0] er;
    logic       ef;
    bit         lit;
    int         row, ph;
    el = 7'h7F;
    ec = 5'd0;
    er = 3'd0;
    ef = 1'b0;
    if (en_m) begin
      row = (p / RP) % NR;
      ph  = p % RP;
      er  = 3'(row);
      ef  = (p > 0) && (p % FP == 0);
      if (ph >= BLANK) begin
        lit = 1'b1;
`ifdef MATRIZ_VARREDURA_BRILHO_EN
        lit = (ph - BLANK) < (int'(bri_row) + 1) * (PRESCALE / 8);
`endif
        if (lit) begin
          el = ~(7'b1 << row);
          ec = rom(er, frame_m);
        end
      end
    end
    check("linhas", 32'(linhas), 32'(el));
    check("colunas", 32'(colunas), 32'(ec));
    check("contador", 32'(contador), 32'(er));
    check("quadro_atual", 32'(quadro_atual), 32'(frame_m));
    check("fim_quadro", 32'(fim_quadro), 32'(ef));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_linhas"}, 32'(linhas), 32'h7F);
    check({tag, "_colunas"}, 32'(colunas), 32'h0);
    check({tag, "_contador"}, 32'(contador), 32'h0);
    check({tag, "_quadro"}, 32'(quadro_atual), 32'h0);
    check({tag, "_fim"}, 32'(fim_quadro), 32'h0);
  endtask

  initial begin
    int last_fim, period, waited;

    // Reset and idle
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) cycle();

    // Nominal scan, frame switch requested during row 2 of the first frame
`ifdef MATRIZ_VARREDURA_BRILHO_EN
    brilho = 3'd1;
`endif
    habilita = 1'b1;
    last_fim = -1;
    period   = 0;
    for (int i = 0; i < 2 * FP + 10; i++) begin
      cycle();
      if (fim_quadro) begin
        if (last_fim >= 0) period = i - last_fim;
        last_fim = i;
      end
      if (en_m && p == 2 * RP + 1) quadro_sel = 3'd3;
    end
    check("fim_period", 32'(period), 32'(FP));
`ifdef MATRIZ_VARREDURA_BRILHO_EN
    brilho = 3'd7;
    for (int i = 0; i < FP; i++) cycle();
`endif

    // Disable during the show phase of row 4, then re-enable
    waited = 0;
    while (!(en_m && (p / RP) % NR == 4 && p % RP == BLANK + 1) && waited < 2 * FP) begin
      cycle();
      waited++;
    end
    check("reach_row4", 32'(waited < 2 * FP), 32'd1);
    habilita = 1'b0;
    cycle();
    cycle();
    habilita = 1'b1;
    for (int i = 0; i < RP + 4; i++) cycle();

    // Asynchronous reset pulse between edges during the show of row 5
    waited = 0;
    while (!(en_m && (p / RP) % NR == 5 && p % RP >= BLANK) && waited < 2 * FP) begin
      cycle();
      waited++;
    end
    check("reach_row5", 32'(waited < 2 * FP), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cycle();

    // Randomized enable, frame and brightness stimulus
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (habilita) habilita = ($urandom_range(0, 149) != 0);
      else          habilita = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) quadro_sel = 3'($urandom_range(0, 7));
`ifdef MATRIZ_VARREDURA_BRILHO_EN
      if ($urandom_range(0, 9) == 0) brilho = 3'($urandom_range(0, 7));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
